cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
- Source-side half of a four-phase req/ack clock-domain-crossing channel.
- Captures a multi-bit word through a valid/ready input interface and holds it stable on a crossing bus.
- Raises req, waits for the destination's ack (asynchronous, synchronized internally through an N-stage register chain), and completes the return-to-zero phase before accepting the next word.
- Sits in the source clock domain; its partner receiver lives in the destination domain.

Parameters:
- WIDTH, 8, width of the transferred data word
- N, 2, depth of the internal ack synchronizer chain (minimum 2)

Ports:
- clk  input  1  source-domain clock
- rst_n  input  1  asynchronous active-low reset
- s_data  input  WIDTH  word to transfer
- s_valid  input  1  s_data valid
- s_ready  output  1  block can accept a word this cycle
- xfer_data  output  WIDTH  registered crossing bus, stable from req rise until ack fall
- xfer_req  output  1  registered request to destination domain
- xfer_ack  input  1  asynchronous acknowledge from destination domain
- busy  output  1  transfer in progress
- done  output  1  single-cycle pulse when a transfer fully completes

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE
  - xfer_req = 0, xfer_data = 0, done = 0
  - all ack synchronizer stages = 0
  - busy = 0, s_ready = 1
- Ack synchronizer: N flops; ack_s is the last stage. There is no other path from xfer_ack into any logic. Tag the flops as async registers.
- s_ready is combinational: (state == IDLE) && !ack_s.
- Accept: on s_valid && s_ready, xfer_data <= s_data and state -> SETUP.
- SETUP: one cycle, guaranteeing data is stable at least one cycle before req rises. xfer_req <= 1, state -> REQ_HI.
- REQ_HI: hold until ack_s == 1, then xfer_req <= 0 and state -> REQ_LO.
- REQ_LO: hold until ack_s == 0, then state -> IDLE and done <= 1 for exactly one cycle.
- busy = (state != IDLE).
- xfer_data must not change outside an accept edge. It holds its value after completion until the next accept.
- Latency, with the destination looping ack = req (zero destination delay), edges counted from the accept edge 0:
  - xfer_req high after edge 1
  - ack_s high after edge 1+N
  - xfer_req low after edge 2+N
  - ack_s low after edge 2+2N
  - IDLE and done high after edge 3+2N
  - next accept no earlier than edge 4+2N (period 8 cycles for N=2)
- Boundary conditions:
  - s_valid while busy: ignored (s_ready = 0). Input must hold its word until the handshake completes.
  - ack_s high while IDLE (stale or spurious ack): s_ready = 0 until ack_s falls. No req is raised.
  - ack_s falling early during REQ_HI: no effect; keep waiting for a 1.
  - ack_s high glitch in REQ_LO: keep waiting for 0; req stays low.
  - Reset mid-transfer: immediate return to reset values and xfer_req drops asynchronously. The destination side must be reset together.
  - No timeout: a missing ack holds the block busy indefinitely.
  - s_valid and ack_s falling in the same cycle as the REQ_LO -> IDLE transition: no accept that cycle. The accept occurs the following cycle.

Test Plan:
- N=2, ack = req loopback, s_data=0xA5 with valid one cycle -> xfer_data=0xA5 after edge 0, xfer_req rises after edge 1 and falls after edge 4, done pulses after edge 7 for one cycle.
- Back-to-back: s_valid held high with 0x11 then 0x22 -> accepts at edges 0 and 8 only. xfer_data changes only on those edges and never while xfer_req=1.
- Destination ack delay 10 cycles, randomized per phase -> xfer_req stays high until 2 cycles after ack rise, busy high throughout, s_ready low throughout, done exactly once.
- Force xfer_ack=1 while IDLE, s_valid=1 -> s_ready=0, xfer_req stays 0. Release ack -> accept exactly 2 cycles after release.
- Assert rst_n low while in REQ_HI -> xfer_req=0 and busy=0 within the same cycle with no clock edge, xfer_data=0, done never pulses. The next transfer after reset completes normally.
- N=3, loopback -> done pulse after edge 9 and next accept at edge 10.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source-side half of a four-phase req/ack CDC channel. It captures a word over valid/ready,
// holds it on xfer_data, and runs req up / ack up / req down / ack down before accepting again.
module cdc_handshake_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSetup, StReqHi, StReqLo} state_e;

  state_e state_q, state_d;

  (* ASYNC_REG = "TRUE" *) logic [N-1:0] ack_sync_q;
  logic ack_s;

  logic [WIDTH-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic             done_q, done_d;

  // xfer_ack reaches the rest of the block only through this chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[N-2:0], xfer_ack};
    end
  end

  assign ack_s = ack_sync_q[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      req_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      req_q  <= req_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A stale ack still in flight blocks acceptance until it clears.
        if (s_valid && !ack_s) begin
          data_d  = s_data;
          state_d = StSetup;
        end
      end
      StSetup: begin
        req_d   = 1'b1;
        state_d = StReqHi;
      end
      StReqHi: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == StIdle) && !ack_s;
    busy      = (state_q != StIdle);
    xfer_data = data_q;
    xfer_req  = req_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: loopback latency, back-to-back, randomized
// destination delays, stale ack, mid-transfer reset, and an N=3 instance.
module tb_cdc_handshake_tx;

  localparam int unsigned NM = 2;
  localparam int unsigned N3 = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] xfer_data;
  logic       xfer_req;
  logic       xfer_ack;
  logic       busy;
  logic       done;

  logic       loopback;
  logic       ack_drv;

  logic [7:0] s_data3;
  logic       s_valid3;
  logic       s_ready3;
  logic [7:0] xfer_data3;
  logic       xfer_req3;
  logic       busy3;
  logic       done3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign xfer_ack = loopback ? xfer_req : ack_drv;

  cdc_handshake_tx #(.WIDTH(8), .N(NM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .xfer_data(xfer_data),
    .xfer_req (xfer_req),
    .xfer_ack (xfer_ack),
    .busy     (busy),
    .done     (done)
  );

  cdc_handshake_tx #(.WIDTH(8), .N(N3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data3),
    .s_valid  (s_valid3),
    .s_ready  (s_ready3),
    .xfer_data(xfer_data3),
    .xfer_req (xfer_req3),
    .xfer_ack (xfer_req3),
    .busy     (busy3),
    .done     (done3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected timing from the loopback latency rules: edge 0 is the accept edge.
  task automatic loopback_xfer(input logic [7:0] d);
    check_eq("lb_ready_pre", s_ready, 1);
    loopback = 1'b1;
    s_data   = d;
    s_valid  = 1'b1;
    tick();
    s_valid  = 1'b0;
    for (int e = 0; e <= 4 + 2 * NM; e++) begin
      if (e > 0) tick();
      check_eq("lb_req", xfer_req, (e >= 1 && e < 2 + NM));
      check_eq("lb_done", done, (e == 3 + 2 * NM));
      check_eq("lb_busy", busy, (e < 3 + 2 * NM));
      check_eq("lb_data", xfer_data, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int unsigned d1, d2;
    int ndone;
    logic seen;

    rst_n    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    loopback = 1'b1;
    ack_drv  = 1'b0;
    s_data3  = '0;
    s_valid3 = 1'b0;

    #2;
    check_eq("rst_req", xfer_req, 0);
    check_eq("rst_data", xfer_data, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", s_ready, 1);
    #21 rst_n = 1'b1;
    tick();

    // Basic loopback transfer.
    loopback_xfer(8'hA5);

    // Back-to-back with s_valid held: accepts every 4+2N edges only.
    s_data  = 8'h11;
    s_valid = 1'b1;
    tick();
    for (int e = 0; e < 2 * (4 + 2 * NM); e++) begin
      int p;
      if (e > 0) tick();
      p = e % (4 + 2 * NM);
      check_eq("b2b_data", xfer_data, (e < 4 + 2 * NM) ? 8'h11 : 8'h22);
      check_eq("b2b_busy", busy, (p != 3 + 2 * NM));
      check_eq("b2b_req", xfer_req, (p >= 1 && p < 2 + NM));
      check_eq("b2b_done", done, (p == 3 + 2 * NM));
      if (e == 0) s_data = 8'h22;
    end
    s_valid = 1'b0;
    tick();
    check_eq("b2b_idle", busy, 0);
    check_eq("b2b_ready", s_ready, 1);

    // Destination with random per-phase delays.
    loopback = 1'b0;
    ack_drv  = 1'b0;
    for (int t = 0; t < 4; t++) begin
      d  = 8'($urandom);
      d1 = $urandom_range(0, 10);
      d2 = $urandom_range(0, 10);
      s_data  = d;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      check_eq("rd_data", xfer_data, d);
      check_eq("rd_busy0", busy, 1);
      tick();
      check_eq("rd_req_rise", xfer_req, 1);
      repeat (d1) begin
        tick();
        check_eq("rd_req_wait", xfer_req, 1);
        check_eq("rd_ready_hi", s_ready, 0);
        check_eq("rd_done_hi", done, 0);
        check_eq("rd_busy_hi", busy, 1);
      end
      ack_drv = 1'b1;
      for (int e = 1; e <= NM + 1; e++) begin
        tick();
        check_eq("rd_req_fall", xfer_req, (e < NM + 1));
        check_eq("rd_busy_mid", busy, 1);
        check_eq("rd_done_mid", done, 0);
      end
      repeat (d2) begin
        tick();
        check_eq("rd_req_lo", xfer_req, 0);
        check_eq("rd_ready_lo", s_ready, 0);
        check_eq("rd_busy_lo", busy, 1);
        check_eq("rd_done_lo", done, 0);
      end
      ack_drv = 1'b0;
      ndone   = 0;
      for (int e = 1; e <= NM + 2; e++) begin
        tick();
        check_eq("rd_done", done, (e == NM + 1));
        check_eq("rd_busy_end", busy, (e < NM + 1));
        if (done) ndone++;
      end
      check_eq("rd_done_once", ndone, 1);
    end

    // Stale ack while idle blocks acceptance until it clears.
    ack_drv = 1'b1;
    repeat (NM + 1) tick();
    check_eq("stale_ready", s_ready, 0);
    s_data  = 8'h3C;
    s_valid = 1'b1;
    repeat (4) begin
      tick();
      check_eq("stale_ready_hold", s_ready, 0);
      check_eq("stale_req", xfer_req, 0);
      check_eq("stale_busy", busy, 0);
    end
    ack_drv = 1'b0;
    for (int e = 1; e <= NM + 1; e++) begin
      tick();
      check_eq("stale_accept", busy, (e == NM + 1));
      check_eq("stale_ready_rel", s_ready, (e == NM));
    end
    check_eq("stale_data", xfer_data, 8'h3C);
    s_valid  = 1'b0;
    loopback = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check_eq("stale_done_seen", seen, 1);
    tick();

    // Asynchronous reset while waiting in the request-high phase.
    s_data  = 8'h5A;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    check_eq("arst_req_pre", xfer_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", xfer_req, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_data", xfer_data, 0);
    check_eq("arst_ready", s_ready, 1);
    repeat (2) begin
      tick();
      check_eq("arst_done", done, 0);
      check_eq("arst_req_hold", xfer_req, 0);
    end
    #2 rst_n = 1'b1;
    tick();
    check_eq("arst_done_after", done, 0);
    loopback_xfer(8'hC3);

    // N=3 loopback: done after edge 3+2N, next accept one edge later.
    check_eq("n3_ready", s_ready3, 1);
    s_data3  = 8'h77;
    s_valid3 = 1'b1;
    tick();
    for (int e = 0; e <= 4 + 2 * N3; e++) begin
      if (e > 0) tick();
      check_eq("n3_done", done3, (e == 3 + 2 * N3));
      check_eq("n3_data", xfer_data3, (e < 4 + 2 * N3) ? 8'h77 : 8'h88);
      check_eq("n3_busy", busy3, (e != 3 + 2 * N3));
      if (e == 0) s_data3 = 8'h88;
    end
    s_valid3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
